// File: rtl/magphase_gain_sched_if.sv
// Settings write bus and observed sample-stream handshake for the gain scheduler.
interface magphase_gain_sched_if;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;

  modport master (
    output set_stb, set_addr, set_data, mon_tvalid, mon_tready, mon_tlast
  );
  modport slave (
    input  set_stb, set_addr, set_data, mon_tvalid, mon_tready, mon_tlast
  );
endinterface

// File: rtl/magphase_gain_sched.sv
// Packet-aligned gain scheduler: committed mag/phase targets are applied at a packet
// boundary, either directly or as a linear ramp over 2^shift stream beats.
module magphase_gain_sched #(
  parameter int unsigned SR_BASE    = 192,
  parameter logic [15:0] MAG_INIT   = 16'h0000,
  parameter logic [15:0] PHASE_INIT = 16'h0000
) (
  input  logic                        ce_clk,
  input  logic                        ce_rstn,
  input  logic                        clear,
  magphase_gain_sched_if.slave        bus,
  output logic [15:0]                 mag_gain,
  output logic [15:0]                 phase_gain,
  output logic [3:0]                  status
);

  localparam int unsigned GW = 16;
  localparam int unsigned DW = 17;
  localparam int unsigned AW = 25;
  localparam int unsigned CW = 9;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RAMP} state_t;

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  state_t r_state, w_state_n;

  logic [GW-1:0]        r_sh_mag, r_sh_ph;
  logic [3:0]           r_sh_shift;
  logic [GW-1:0]        r_tg_mag, r_tg_ph, w_tg_mag_n, w_tg_ph_n;
  logic [3:0]           r_tg_shift, w_tg_shift_n;
  logic [GW-1:0]        r_pn_mag, r_pn_ph, w_pn_mag_n, w_pn_ph_n;
  logic [3:0]           r_pn_shift, w_pn_shift_n;
  logic                 r_pending, w_pending_n;
  logic                 r_sop, w_sop_n;
  logic [GW-1:0]        r_mag, r_ph, w_mag_n, w_ph_n;
  logic [GW-1:0]        r_st_mag, r_st_ph, w_st_mag_n, w_st_ph_n;
  logic signed [DW-1:0] r_dl_mag, r_dl_ph, w_dl_mag_n, w_dl_ph_n;
  logic signed [AW-1:0] r_acc_mag, r_acc_ph, w_acc_mag_n, w_acc_ph_n;
  logic signed [AW-1:0] w_acc_mag_step, w_acc_ph_step;
  logic [GW-1:0]        w_mag_step, w_ph_step;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [3:0]           r_status, w_status_n;

  logic       w_beat, w_boundary, w_last;
  logic       w_wr_mag, w_wr_ph, w_wr_shift, w_commit;
  logic [3:0] w_shift_sat;
  logic       w_unused;

  // Reset asserts asynchronously, releases two clocks after ce_rstn rises
  always_ff @(posedge ce_clk or negedge ce_rstn) begin
    if (!ce_rstn) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_beat     = bus.mon_tvalid & bus.mon_tready;
  assign w_boundary = (r_sop & ~w_beat) | (w_beat & bus.mon_tlast);
  assign w_wr_mag   = bus.set_stb && (bus.set_addr == 8'(SR_BASE));
  assign w_wr_ph    = bus.set_stb && (bus.set_addr == 8'(SR_BASE + 1));
  assign w_wr_shift = bus.set_stb && (bus.set_addr == 8'(SR_BASE + 2));
  assign w_commit   = bus.set_stb && (bus.set_addr == 8'(SR_BASE + 3));
  assign w_shift_sat = (bus.set_data[3:0] > 4'd8) ? 4'd8 : bus.set_data[3:0];
  assign w_unused   = ^bus.set_data[31:16];

  assign w_acc_mag_step = r_acc_mag + {{(AW-DW){r_dl_mag[DW-1]}}, r_dl_mag};
  assign w_acc_ph_step  = r_acc_ph  + {{(AW-DW){r_dl_ph[DW-1]}},  r_dl_ph};
  assign w_mag_step     = r_st_mag + GW'(w_acc_mag_step >>> r_tg_shift);
  assign w_ph_step      = r_st_ph  + GW'(w_acc_ph_step  >>> r_tg_shift);
  assign w_last         = (r_cnt + CW'(1)) == (CW'(1) << r_tg_shift);

  always_ff @(posedge ce_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n    = r_state;
    w_tg_mag_n   = r_tg_mag;
    w_tg_ph_n    = r_tg_ph;
    w_tg_shift_n = r_tg_shift;
    w_pn_mag_n   = r_pn_mag;
    w_pn_ph_n    = r_pn_ph;
    w_pn_shift_n = r_pn_shift;
    w_pending_n  = r_pending;
    w_mag_n      = r_mag;
    w_ph_n       = r_ph;
    w_st_mag_n   = r_st_mag;
    w_st_ph_n    = r_st_ph;
    w_dl_mag_n   = r_dl_mag;
    w_dl_ph_n    = r_dl_ph;
    w_acc_mag_n  = r_acc_mag;
    w_acc_ph_n   = r_acc_ph;
    w_cnt_n      = r_cnt;
    w_sop_n      = w_beat ? bus.mon_tlast : r_sop;

    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_tg_mag_n   = r_sh_mag;
          w_tg_ph_n    = r_sh_ph;
          w_tg_shift_n = r_sh_shift;
          w_state_n    = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_commit) begin
          w_tg_mag_n   = r_sh_mag;
          w_tg_ph_n    = r_sh_ph;
          w_tg_shift_n = r_sh_shift;
        end else if (w_boundary) begin
          if (r_tg_shift == 4'd0) begin
            w_mag_n   = r_tg_mag;
            w_ph_n    = r_tg_ph;
            w_state_n = S_IDLE;
          end else begin
            w_st_mag_n  = r_mag;
            w_st_ph_n   = r_ph;
            w_dl_mag_n  = $signed({1'b0, r_tg_mag}) - $signed({1'b0, r_mag});
            w_dl_ph_n   = $signed({1'b0, r_tg_ph}) - $signed({1'b0, r_ph});
            w_acc_mag_n = '0;
            w_acc_ph_n  = '0;
            w_cnt_n     = '0;
            w_state_n   = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (w_beat) begin
          w_acc_mag_n = w_acc_mag_step;
          w_acc_ph_n  = w_acc_ph_step;
          w_mag_n     = w_mag_step;
          w_ph_n      = w_ph_step;
          w_cnt_n     = r_cnt + CW'(1);
        end
        // Ramp end: a same-edge commit is newest, otherwise any queued set is armed
        if (w_beat && w_last) begin
          w_mag_n     = r_tg_mag;
          w_ph_n      = r_tg_ph;
          w_pending_n = 1'b0;
          if (w_commit) begin
            w_tg_mag_n   = r_sh_mag;
            w_tg_ph_n    = r_sh_ph;
            w_tg_shift_n = r_sh_shift;
            w_state_n    = S_ARMED;
          end else if (r_pending) begin
            w_tg_mag_n   = r_pn_mag;
            w_tg_ph_n    = r_pn_ph;
            w_tg_shift_n = r_pn_shift;
            w_state_n    = S_ARMED;
          end else begin
            w_state_n    = S_IDLE;
          end
        end else if (w_commit) begin
          w_pn_mag_n   = r_sh_mag;
          w_pn_ph_n    = r_sh_ph;
          w_pn_shift_n = r_sh_shift;
          w_pending_n  = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (clear) begin
      w_state_n    = S_IDLE;
      w_pending_n  = 1'b0;
      w_mag_n      = r_mag;
      w_ph_n       = r_ph;
      w_tg_mag_n   = r_tg_mag;
      w_tg_ph_n    = r_tg_ph;
      w_tg_shift_n = r_tg_shift;
    end

    w_status_n = {w_pending_n, w_state_n == S_ARMED, w_state_n == S_RAMP, w_sop_n};
  end

  always_ff @(posedge ce_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sh_mag   <= MAG_INIT;
      r_sh_ph    <= PHASE_INIT;
      r_sh_shift <= '0;
    end else begin
      if (w_wr_mag)   r_sh_mag   <= bus.set_data[15:0];
      if (w_wr_ph)    r_sh_ph    <= bus.set_data[15:0];
      if (w_wr_shift) r_sh_shift <= w_shift_sat;
    end
  end

  always_ff @(posedge ce_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tg_mag   <= MAG_INIT;
      r_tg_ph    <= PHASE_INIT;
      r_tg_shift <= '0;
      r_pn_mag   <= MAG_INIT;
      r_pn_ph    <= PHASE_INIT;
      r_pn_shift <= '0;
      r_pending  <= 1'b0;
      r_sop      <= 1'b1;
      r_mag      <= MAG_INIT;
      r_ph       <= PHASE_INIT;
      r_st_mag   <= MAG_INIT;
      r_st_ph    <= PHASE_INIT;
      r_dl_mag   <= '0;
      r_dl_ph    <= '0;
      r_acc_mag  <= '0;
      r_acc_ph   <= '0;
      r_cnt      <= '0;
      r_status   <= 4'b0001;
    end else begin
      r_tg_mag   <= w_tg_mag_n;
      r_tg_ph    <= w_tg_ph_n;
      r_tg_shift <= w_tg_shift_n;
      r_pn_mag   <= w_pn_mag_n;
      r_pn_ph    <= w_pn_ph_n;
      r_pn_shift <= w_pn_shift_n;
      r_pending  <= w_pending_n;
      r_sop      <= w_sop_n;
      r_mag      <= w_mag_n;
      r_ph       <= w_ph_n;
      r_st_mag   <= w_st_mag_n;
      r_st_ph    <= w_st_ph_n;
      r_dl_mag   <= w_dl_mag_n;
      r_dl_ph    <= w_dl_ph_n;
      r_acc_mag  <= w_acc_mag_n;
      r_acc_ph   <= w_acc_ph_n;
      r_cnt      <= w_cnt_n;
      r_status   <= w_status_n;
    end
  end

  assign mag_gain   = r_mag;
  assign phase_gain = r_ph;
  assign status     = r_status;

endmodule

// File: doc/magphase_gain_sched.md
MAGPHASE_GAIN_SCHED -- requirements
Module: magphase_gain_sched

Interface
REQ-001 SHALL have parameter SR_BASE, default 192: settings address of the mag shadow register; phase = SR_BASE+1, ramp = SR_BASE+2, commit = SR_BASE+3.
REQ-002 SHALL have parameter MAG_INIT, default 16'h0000: mag_gain value applied at reset.
REQ-003 SHALL have parameter PHASE_INIT, default 16'h0000: phase_gain value applied at reset.
REQ-004 SHALL have port ce_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port ce_rstn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port set_stb, input, 1: settings write strobe.
REQ-007 SHALL have port set_addr, input, 8: settings address.
REQ-008 SHALL have port set_data, input, 32: settings data.
REQ-009 SHALL have port clear, input, 1: synchronous abort of any commit or ramp.
REQ-010 SHALL have port mon_tvalid, mon_tready, mon_tlast, input, 1 each: the sample stream into the gain datapath, observed only; beat = mon_tvalid & mon_tready.
REQ-011 SHALL have port mag_gain, output, 16: gain fed to the magnitude multiplier.
REQ-012 SHALL have port phase_gain, output, 16: gain fed to the phase multiplier.
REQ-013 SHALL have port status, output, 4: {pending, armed, ramping, sop}.

Function
REQ-014 Writes to SR_BASE / SR_BASE+1 SHALL load 16-bit unsigned shadow targets from set_data[15:0] and SHALL NOT change the outputs.
REQ-015 A write to SR_BASE+2 SHALL load shift = set_data[3:0], saturated to 8; ramp length = 2^shift beats.
REQ-016 A write to SR_BASE+3 with any data SHALL be a commit; it snapshots both shadow targets and shift into the active targets.
REQ-017 The sop flag SHALL be 1 after reset, set by a beat with mon_tlast=1, and cleared by a beat with mon_tlast=0.
REQ-018 The FSM SHALL have states IDLE, ARMED and RAMP.
REQ-019 IDLE -> ARMED on a commit.
REQ-020 ARMED -> RAMP at the edge where a boundary occurs: (sop & ~beat) | (beat & mon_tlast). Gain outputs SHALL therefore first change at the first beat of a packet, never mid-packet.
REQ-021 On entry to RAMP: start = current outputs; delta = target - start, 17-bit signed; acc = 0.
REQ-022 In RAMP, each beat SHALL do acc += delta (25-bit signed) and output = start + (acc >>> shift), arithmetic shift.
REQ-023 After exactly 2^shift beats the outputs SHALL equal the targets exactly; the FSM then exits RAMP.
REQ-024 With shift = 0 the targets SHALL be applied on the edge that leaves ARMED, and the FSM SHALL return to IDLE with no RAMP beats.
REQ-025 Mag and phase SHALL ramp together from one beat counter.
REQ-026 A commit in ARMED SHALL re-snapshot the targets and stay ARMED.
REQ-027 A commit in RAMP SHALL set pending and snapshot into a second target set.
REQ-028 At ramp end with pending=1 the FSM SHALL go to ARMED, load the second set and clear pending; otherwise it goes to IDLE.
REQ-029 A commit on the same edge as ramp end SHALL be treated as pending (go to ARMED).
REQ-030 clear SHALL force IDLE and pending=0 next edge, with the outputs holding their current values; clear has priority over a simultaneous commit.
REQ-031 No beats SHALL freeze the RAMP outputs; there is no timeout.
REQ-032 The outputs SHALL be registered; latency from the qualifying edge to the output change is 1 cycle.
REQ-033 status SHALL be registered, with armed=(ARMED), ramping=(RAMP).

Reset
REQ-034 ce_rstn low SHALL asynchronously set: state IDLE, mag_gain=MAG_INIT, phase_gain=PHASE_INIT, shadows = INIT values, shift=0, pending=0, sop=1, acc=0, status=4'b0001.
REQ-035 Deassertion SHALL be synchronised internally; reset asserted mid-ramp SHALL abandon the ramp with no partial output retained.

Verification
REQ-036 Reset, write mag=0x0400, phase=0x0200 with no commit, drive 10 beats -> outputs stay 0x0000/0x0000.
REQ-037 shift=0, commit between packets (sop=1, no beat) -> next edge outputs 0x0400/0x0200, state IDLE.
REQ-038 Commit on beat 3 of an 8-beat packet -> outputs unchanged through beat 8 (tlast); new values from the first beat of the next packet.
REQ-039 Mag 0x0000->0x0100, shift=2 -> outputs over 4 beats 0x0040, 0x0080, 0x00C0, 0x0100; then IDLE.
REQ-040 Mag 0x0100->0x0000 (negative delta), shift=3 -> decreases by 0x20 per beat, ends exactly at 0x0000.
REQ-041 Commit during ramp, then clear in ARMED -> pending set then cleared; clear+commit on the same edge -> IDLE, outputs held.
